pll_lock_seq: RTL and testbench



---
 rtl/pll_lock_seq_if.sv | 44 ++++
 rtl/pll_lock_seq.sv | 142 ++++++++++++++
 tb/tb_pll_lock_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_seq_if.sv
// Purpose: status/control bundle between the PLL lock sequencer and its surroundings.
// Latency: none (plain wires); all sequencer-driven fields are registered inside pll_lock_seq.
// Backpressure: none; level signals plus a single-cycle relock pulse.
// Ports (master = sequencer side):
//   pll_locked  in   raw PLL LOCK, asynchronous to the sequencer clock
//   req_relock  in   single-cycle request to restart the sequence
//   pll_rst     out  PLL reset, active-high
//   sys_rst     out  downstream reset, active-high
//   ready       out  PLL locked and qualified
//   fail        out  retries exhausted
//   retry_cnt   out  timeouts since last success or relock
//   lol_count   out  loss-of-lock events while running, saturating
interface pll_lock_seq_if;
  logic       pll_locked;
  logic       req_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lol_count;

  modport master (
    input  pll_locked,
    input  req_relock,
    output pll_rst,
    output sys_rst,
    output ready,
    output fail,
    output retry_cnt,
    output lol_count
  );

  modport slave (
    output pll_locked,
    output req_relock,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fail,
    input  retry_cnt,
    input  lol_count
  );
endinterface

// File: rtl/pll_lock_seq.sv
// Purpose: reset/lock sequencer for the pixel-clock PLL with retry, fault latch and relock.
// Latency: lock loss reaches sys_rst within 3 edges (2 synchroniser + 1 FSM); outputs registered.
// Backpressure: none; req_relock is accepted on any cycle and always wins.
// Ports:
//   clk_25m  in  board reference clock (only clock)
//   rst_n    in  asynchronous active-low reset
//   bus      pll_lock_seq_if.master: pll_locked/req_relock in; pll_rst, sys_rst,
//            ready, fail, retry_cnt, lol_count out
module pll_lock_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 2500,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic               clk_25m,
  input  logic               rst_n,
  pll_lock_seq_if.master     bus
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_t;

  // Terminal timer values: each state compares against "cycles - 1" since the
  // timer starts at 0 on entry.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] timer, nxt_timer;
  logic [3:0]       retry_q, nxt_retry;
  logic [7:0]       lol_q, nxt_lol;

  logic lock_meta, lock_s;

  logic pll_rst_q, sys_rst_q, ready_q, fail_q;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Next-state logic. Timer defaults to zero so every state change (and a
  // relock into RESET_HOLD) restarts it; only staying put advances it.
  always_comb begin
    nxt_state = state;
    nxt_timer = '0;
    nxt_retry = retry_q;
    nxt_lol   = lol_q;

    if (bus.req_relock) begin
      // Relock overrides a coincident timeout or lock loss: no counter bumps.
      nxt_state = RESET_HOLD;
      nxt_retry = '0;
    end else begin
      case (state)
        RESET_HOLD: begin
          if (timer == RST_LAST) nxt_state = WAIT_LOCK;
          else                   nxt_timer = timer + CNT_W'(1);
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            nxt_state = STABLE;
          end else if (timer == TO_LAST) begin
            nxt_retry = retry_q + 4'd1;
            nxt_state = (nxt_retry == RETRY_MAX) ? FAULT : RESET_HOLD;
          end else begin
            nxt_timer = timer + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            // Glitch during qualification: fresh lock window, not a retry.
            nxt_state = WAIT_LOCK;
          end else if (timer == STABLE_LAST) begin
            nxt_state = RUN;
            nxt_retry = '0;
          end else begin
            nxt_timer = timer + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            nxt_state = RESET_HOLD;
            if (lol_q != 8'hFF) nxt_lol = lol_q + 8'd1;
          end
        end
        FAULT: begin
          nxt_state = FAULT;
        end
        default: begin
          nxt_state = RESET_HOLD;
        end
      endcase
    end
  end

  // State and outputs share one register stage; outputs decode the next state
  // so they change on the same edge as the state, glitch-free.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_HOLD;
      timer     <= '0;
      retry_q   <= '0;
      lol_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= nxt_state;
      timer     <= nxt_timer;
      retry_q   <= nxt_retry;
      lol_q     <= nxt_lol;
      pll_rst_q <= (nxt_state == RESET_HOLD) || (nxt_state == FAULT);
      sys_rst_q <= (nxt_state != RUN);
      ready_q   <= (nxt_state == RUN);
      fail_q    <= (nxt_state == FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.lol_count = lol_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
module tb_pll_lock_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int BUDGET        = 200;

  logic clk_25m = 1'b0;
  logic rst_n;

  pll_lock_seq_if bus();

  pll_lock_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .clk_25m(clk_25m),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #20 clk_25m = ~clk_25m;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  function automatic void sb_push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endfunction

  task automatic check(input logic [31:0] obs);
    sb_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_underflow: observed %0d with no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk_25m);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.pll_rst;
      1:       return bus.ready;
      2:       return bus.sys_rst;
      default: return bus.fail;
    endcase
  endfunction

  // Edges until the selected output reaches val; -1 if the budget expires.
  task automatic count_until(input int sel, input logic val, output int n);
    n = 0;
    while (sig(sel) !== val && n < BUDGET) begin
      tick();
      n++;
    end
    if (sig(sel) !== val) n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.pll_locked = 1'b1;
    bus.req_relock = 1'b0;

    // ---- reset values ----
    tick(); tick(); tick();
    sb_push("rst_pll_rst", 1);  check(32'(bus.pll_rst));
    sb_push("rst_sys_rst", 1);  check(32'(bus.sys_rst));
    sb_push("rst_ready", 0);    check(32'(bus.ready));
    sb_push("rst_fail", 0);     check(32'(bus.fail));
    sb_push("rst_retry", 0);    check(32'(bus.retry_cnt));
    sb_push("rst_lol", 0);      check(32'(bus.lol_count));

    // ---- 1: clean bring-up with lock already present ----
    rst_n = 1'b1;
    sb_push("t1_pll_rst_len", RST_CYCLES);
    count_until(0, 1'b0, n); check(32'(n));
    // lock_s is already high at WAIT_LOCK entry: 1 edge into STABLE + 8 stable.
    sb_push("t1_ready_delay", 1 + STABLE_CYCLES);
    count_until(1, 1'b1, n); check(32'(n));
    sb_push("t1_sys_rst", 0);   check(32'(bus.sys_rst));
    sb_push("t1_retry", 0);     check(32'(bus.retry_cnt));

    // ---- 2: no lock ever -> two timeouts -> FAULT ----
    #5 rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_push("t2_pll_rst_len1", RST_CYCLES);
    count_until(0, 1'b0, n); check(32'(n));
    sb_push("t2_wait_len1", LOCK_TIMEOUT);
    count_until(0, 1'b1, n); check(32'(n));
    sb_push("t2_retry1", 1);    check(32'(bus.retry_cnt));
    sb_push("t2_fail_early", 0); check(32'(bus.fail));
    sb_push("t2_pll_rst_len2", RST_CYCLES);
    count_until(0, 1'b0, n); check(32'(n));
    sb_push("t2_wait_len2", LOCK_TIMEOUT);
    count_until(3, 1'b1, n); check(32'(n));
    sb_push("t2_retry2", MAX_RETRY); check(32'(bus.retry_cnt));
    for (int i = 0; i < 50; i++) tick();
    sb_push("t2_fault_pll_rst", 1); check(32'(bus.pll_rst));
    sb_push("t2_fault_fail", 1);    check(32'(bus.fail));
    sb_push("t2_fault_ready", 0);   check(32'(bus.ready));

    // ---- 5: relock out of FAULT ----
    bus.pll_locked = 1'b1;
    bus.req_relock = 1'b1;
    tick();
    bus.req_relock = 1'b0;
    sb_push("t5_fail", 0);      check(32'(bus.fail));
    sb_push("t5_retry", 0);     check(32'(bus.retry_cnt));
    sb_push("t5_pll_rst", 1);   check(32'(bus.pll_rst));
    sb_push("t5_pll_rst_len", RST_CYCLES);
    count_until(0, 1'b0, n); check(32'(n));
    sb_push("t5_ready_delay", 1 + STABLE_CYCLES);
    count_until(1, 1'b1, n); check(32'(n));
    sb_push("t5_sys_rst", 0);   check(32'(bus.sys_rst));

    // ---- 3: one-cycle glitch after 5 stable cycles ----
    bus.req_relock = 1'b1;
    tick();
    bus.req_relock = 1'b0;
    sb_push("t3_pll_rst_len", RST_CYCLES);
    count_until(0, 1'b0, n); check(32'(n));
    for (int i = 0; i < 5; i++) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    // Glitch reaches the FSM at W+8, WAIT_LOCK again, STABLE at W+9, RUN at W+17.
    sb_push("t3_ready_delay", 9 + STABLE_CYCLES);
    count_until(1, 1'b1, n); check(32'(6 + n));
    sb_push("t3_retry", 0);     check(32'(bus.retry_cnt));

    // ---- 4: loss of lock in RUN ----
    bus.pll_locked = 1'b0;
    sb_push("t4_lol_response", 3);
    count_until(2, 1'b1, n); check(32'(n));
    sb_push("t4_ready", 0);     check(32'(bus.ready));
    sb_push("t4_lol1", 1);      check(32'(bus.lol_count));
    bus.pll_locked = 1'b1;
    sb_push("t4_pll_rst_len", RST_CYCLES);
    count_until(0, 1'b0, n); check(32'(n));
    sb_push("t4_relock_delay", 1 + STABLE_CYCLES);
    count_until(1, 1'b1, n); check(32'(n));
    for (int i = 0; i < 300; i++) begin
      bus.pll_locked = 1'b0;
      count_until(2, 1'b1, n);
      bus.pll_locked = 1'b1;
      sb_push("t4_lol_sat", (i + 2 > 255) ? 255 : i + 2);
      check(32'(bus.lol_count));
      count_until(1, 1'b1, n);
    end

    // ---- 6a: rst_n asserted mid-STABLE ----
    bus.req_relock = 1'b1;
    tick();
    bus.req_relock = 1'b0;
    count_until(0, 1'b0, n);
    tick(); tick(); tick();
    sb_push("t6_pre_pll_rst", 0); check(32'(bus.pll_rst));
    rst_n = 1'b0;
    #2;
    sb_push("t6_async_pll_rst", 1); check(32'(bus.pll_rst));
    sb_push("t6_async_sys_rst", 1); check(32'(bus.sys_rst));
    sb_push("t6_async_ready", 0);   check(32'(bus.ready));
    sb_push("t6_async_fail", 0);    check(32'(bus.fail));
    sb_push("t6_async_retry", 0);   check(32'(bus.retry_cnt));
    sb_push("t6_async_lol", 0);     check(32'(bus.lol_count));

    // ---- 6b: relock on the same cycle as a WAIT_LOCK timeout ----
    bus.pll_locked = 1'b0;
    tick();
    rst_n = 1'b1;
    count_until(0, 1'b0, n);
    sb_push("t6_wait_len", LOCK_TIMEOUT);
    count_until(0, 1'b1, n); check(32'(n));
    sb_push("t6_retry1", 1);    check(32'(bus.retry_cnt));
    count_until(0, 1'b0, n);
    for (int i = 0; i < LOCK_TIMEOUT - 1; i++) tick();
    bus.req_relock = 1'b1;
    tick();
    bus.req_relock = 1'b0;
    sb_push("t6_relock_retry", 0);   check(32'(bus.retry_cnt));
    sb_push("t6_relock_fail", 0);    check(32'(bus.fail));
    sb_push("t6_relock_pll_rst", 1); check(32'(bus.pll_rst));
    sb_push("t6_relock_rst_len", RST_CYCLES);
    count_until(0, 1'b0, n); check(32'(n));
    sb_push("t6_next_wait_len", LOCK_TIMEOUT);
    count_until(0, 1'b1, n); check(32'(n));
    sb_push("t6_next_retry", 1); check(32'(bus.retry_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
